peribus_timer: RTL and testbench

- Memory-mapped down-counting timer that acts as a responder on the data-memory peripheral bus (peribus).
- The CPU data path is the initiator: it writes control, period and count registers and reads status.
- On expiry the timer raises a level interrupt request towards the CPU interrupt mux. The request holds until the CPU acknowledges it or clears it.
- Runs entirely in the 50 MHz peribus clock domain.

---
 rtl/peribus_timer.sv | 179 +++++++++++++++++
 tb/tb_peribus_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peribus_timer.sv
// peribus_timer: memory-mapped down-counting timer acting as a peribus responder.
// Registers: 0 CTRL {AR,IE,EN}, 1 PERIOD, 2 COUNT, 3 STATUS {EN,EXP}.
// The run state (IDLE/RUN) is the EN bit of CTRL; a level interrupt follows EXP & IE.
module peribus_timer #(
    parameter int PRESCALE = 50000,
    parameter int WIDTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        write_enable,
    input  logic [1:0]  addr,
    input  logic [15:0] in_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        int_ack,
    output logic        interrupt
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [PW-1:0]    PRE_ZERO = PW'(0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r, state_next_s;
    logic               ie_r, ar_r, exp_r;
    logic [WIDTH-1:0]   period_r, count_r;
    logic [PW-1:0]      pre_r;
    logic [15:0]        out_data_r;
    logic               out_valid_r, interrupt_r;

    logic               wr_ctrl_s, wr_period_s, wr_count_s, wr_status_s, rd_s;
    logic               tick_s, tick_eff_s, clear_s;
    logic [WIDTH-1:0]   count_next_s;
    logic               exp_next_s;
    logic [PW-1:0]      pre_next_s;
    logic [15:0]        rd_data_s;

    // Bus access decode into per-register write strobes and a read strobe.
    always_comb begin
        wr_ctrl_s   = 1'b0;
        wr_period_s = 1'b0;
        wr_count_s  = 1'b0;
        wr_status_s = 1'b0;
        rd_s        = sel & ~write_enable;
        if (sel && write_enable) begin
            case (addr)
                2'd0:    wr_ctrl_s   = 1'b1;
                2'd1:    wr_period_s = 1'b1;
                2'd2:    wr_count_s  = 1'b1;
                2'd3:    wr_status_s = 1'b1;
                default: wr_ctrl_s   = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // Tick qualification: a COUNT write or a CTRL write dropping EN swallows the tick.
    always_comb begin
        tick_s     = (state_r == RUN) && (pre_r == PRE_LAST);
        tick_eff_s = tick_s && !wr_count_s && !(wr_ctrl_s && !in_data[0]);
        clear_s    = int_ack | (wr_status_s & in_data[0]);
    end

    // Run-state register (EN bit).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next run state: CTRL writes win over the one-shot auto-stop.
    always_comb begin
        state_next_s = state_r;
        if (wr_ctrl_s) begin
            state_next_s = in_data[0] ? RUN : IDLE;
        end else if (tick_eff_s && (count_r == CNT_ZERO) && !ar_r) begin
            state_next_s = IDLE;
        end else begin
            state_next_s = state_r;
        end
    end

    // Counter, expiry flag and prescaler next values; expiry set beats any clear.
    always_comb begin
        count_next_s = count_r;
        exp_next_s   = exp_r;
        pre_next_s   = pre_r;
        if (clear_s) begin
            exp_next_s = 1'b0;
        end else begin
            exp_next_s = exp_r;
        end
        if (wr_count_s) begin
            count_next_s = in_data[WIDTH-1:0];
        end else if (tick_eff_s) begin
            if (count_r != CNT_ZERO) begin
                count_next_s = count_r - CNT_ONE;
            end else begin
                exp_next_s = 1'b1;
                if (ar_r) begin
                    count_next_s = period_r;
                end else begin
                    count_next_s = count_r;
                end
            end
        end else begin
            count_next_s = count_r;
        end
        if ((state_r == IDLE) || (state_next_s == IDLE)) begin
            pre_next_s = PRE_ZERO;
        end else if (tick_s) begin
            pre_next_s = PRE_ZERO;
        end else begin
            pre_next_s = pre_r + PRE_ONE;
        end
    end

    // Read-data mux; unused bits read as zero.
    always_comb begin
        rd_data_s = 16'h0000;
        case (addr)
            2'd0:    rd_data_s = {13'd0, ar_r, ie_r, (state_r == RUN)};
            2'd1:    rd_data_s = 16'(period_r);
            2'd2:    rd_data_s = 16'(count_r);
            2'd3:    rd_data_s = {14'd0, (state_r == RUN), exp_r};
            default: rd_data_s = 16'h0000;
        endcase
    end

    // Control, period, counter, expiry and prescaler state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_r     <= 1'b0;
            ar_r     <= 1'b0;
            period_r <= CNT_ZERO;
            count_r  <= CNT_ZERO;
            exp_r    <= 1'b0;
            pre_r    <= PRE_ZERO;
        end else begin
            if (wr_ctrl_s) begin
                ie_r <= in_data[1];
                ar_r <= in_data[2];
            end
            if (wr_period_s) begin
                period_r <= in_data[WIDTH-1:0];
            end
            count_r <= count_next_s;
            exp_r   <= exp_next_s;
            pre_r   <= pre_next_s;
        end
    end

    // Registered read response and interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r  <= 16'h0000;
            out_valid_r <= 1'b0;
            interrupt_r <= 1'b0;
        end else begin
            out_valid_r <= rd_s;
            if (rd_s) begin
                out_data_r <= rd_data_s;
            end
            interrupt_r <= exp_r & ie_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign interrupt = interrupt_r;

endmodule

// File: tb/tb_peribus_timer.sv
// Scoreboard bench for peribus_timer: directed scenarios then random traffic,
// checked against a register-level reference model of the timer.
module tb_peribus_timer;
    localparam int PRESCALE = 4;
    localparam int WIDTH    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        write_enable = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] in_data = 16'h0000;
    logic [15:0] out_data;
    logic        out_valid;
    logic        int_ack = 1'b0;
    logic        interrupt;

    peribus_timer #(.PRESCALE(PRESCALE), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .write_enable(write_enable),
        .addr(addr), .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
        .int_ack(int_ack), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;
    logic [15:0] exp_q[$];

    // Reference model state (value visible after the most recent modelled edge).
    bit          m_en, m_ie, m_ar, m_exp, m_int, m_valid;
    logic [15:0] m_period, m_count, m_out;
    int          m_pre;

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {13'd0, m_ar, m_ie, m_en};
            2'd1:    return m_period;
            2'd2:    return m_count;
            default: return {14'd0, m_en, m_exp};
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit s, input bit we,
                              input logic [1:0] a, input logic [15:0] d, input bit ack);
        bit wr, tick, en_n, ie_n, ar_n, exp_n;
        logic [15:0] per_n, cnt_n;
        if (rst) begin
            m_en = 0; m_ie = 0; m_ar = 0; m_exp = 0; m_int = 0; m_valid = 0;
            m_period = 0; m_count = 0; m_out = 0; m_pre = 0;
            return;
        end
        wr = s && we;
        m_valid = s && !we;
        if (m_valid) m_out = model_read(a);
        tick = m_en && (m_pre == PRESCALE - 1);
        if (wr && a == 2'd0 && !d[0]) tick = 0;
        if (wr && a == 2'd2) tick = 0;
        en_n = m_en; ie_n = m_ie; ar_n = m_ar; exp_n = m_exp;
        per_n = m_period; cnt_n = m_count;
        if (ack || (wr && a == 2'd3 && d[0])) exp_n = 0;
        if (tick) begin
            if (m_count > 0) cnt_n = m_count - 1;
            else begin
                exp_n = 1;
                if (m_ar) cnt_n = m_period; else en_n = 0;
            end
        end
        if (wr) begin
            case (a)
                2'd0: begin en_n = d[0]; ie_n = d[1]; ar_n = d[2]; end
                2'd1: per_n = d;
                2'd2: cnt_n = d;
                default: ;
            endcase
        end
        m_int = m_exp && m_ie;
        m_pre = (m_en && en_n) ? (m_pre + 1) % PRESCALE : 0;
        m_en = en_n; m_ie = ie_n; m_ar = ar_n; m_exp = exp_n;
        m_period = per_n; m_count = cnt_n;
    endtask

    task automatic drive(input bit rst, input bit s, input bit we, input logic [1:0] a,
                         input logic [15:0] d, input bit ack,
                         input bit use_const, input logic [15:0] cval);
        @(negedge clk);
        reset = rst; sel = s; write_enable = we; addr = a; in_data = d; int_ack = ack;
        if (!rst && s && !we) exp_q.push_back(use_const ? cval : model_read(a));
        model_edge(rst, s, we, a, d, ack);
        if (rst) checking = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'd0, 16'h0, 0, 0, 16'h0);
    endtask
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        drive(0, 1, 1, a, d, 0, 0, 16'h0);
    endtask
    task automatic rd(input logic [1:0] a);
        drive(0, 1, 0, a, 16'h0, 0, 0, 16'h0);
    endtask
    task automatic rdc(input logic [1:0] a, input logic [15:0] v);
        drive(0, 1, 0, a, 16'h0, 0, 1, v);
    endtask
    task automatic timeout(input string what);
        n_cmp++; n_err++;
        $display("FAIL %s: wait expired, got no event, required one", what);
    endtask
    task automatic wait_tick(input string what);
        int k = 0;
        while (!(m_en && m_pre == PRESCALE - 1) && k < 64) begin idle(1); k++; end
        if (k >= 64) timeout(what);
    endtask
    task automatic wait_exp(input string what);
        int k = 0;
        while (!m_exp && k < 64) begin idle(1); k++; end
        if (k >= 64) timeout(what);
    endtask

    // Monitor: sample 1 time unit after each rising edge and score outputs.
    always @(posedge clk) begin
        #1;
        if (checking) begin
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_err++;
                $display("FAIL out_valid: got %b required %b at %0t", out_valid, m_valid, $time);
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL read_data: got %h required no response", out_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL read_data: got %h required %h at %0t", out_data, e, $time);
                    end
                end
            end else begin
                n_cmp++;
                if (out_data !== m_out) begin
                    n_err++;
                    $display("FAIL out_data_hold: got %h required %h at %0t", out_data, m_out, $time);
                end
            end
            n_cmp++;
            if (interrupt !== m_int) begin
                n_err++;
                $display("FAIL interrupt: got %b required %b at %0t", interrupt, m_int, $time);
            end
        end
    end

    initial begin
        bit r_rst, r_s, r_we, r_ack;
        logic [1:0] r_a;
        logic [15:0] r_d;

        // Reset and read every register.
        drive(1, 0, 0, 2'd0, 16'h0, 0, 0, 16'h0);
        drive(1, 0, 0, 2'd0, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) rdc(2'(i), 16'h0000);
        idle(2);

        // Periodic auto-reload with interrupt and acknowledge.
        wr(2'd1, 16'd3);
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0007);
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) rd(2'd2); else idle(1);
        end
        if (!m_int) wait_exp("periodic_expiry");
        idle(1);
        drive(0, 0, 0, 2'd0, 16'h0, 1, 0, 16'h0);
        idle(2);
        rd(2'd3);
        idle(20);

        // One-shot expiry.
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'h0001);
        wr(2'd2, 16'd2);
        wr(2'd0, 16'h0003);
        idle(14);
        rdc(2'd3, 16'h0001);
        idle(100);
        rdc(2'd2, 16'h0000);

        // Interrupt enable gating with EXP pending.
        wr(2'd0, 16'h0000);
        idle(3);
        wr(2'd0, 16'h0002);
        idle(2);
        wr(2'd3, 16'h0001);
        idle(2);

        // Clear and acknowledge on the exact expiry cycle: expiry wins.
        wr(2'd1, 16'd0);
        wr(2'd2, 16'd0);
        wr(2'd0, 16'h0005);
        wait_tick("expiry_cycle");
        drive(0, 1, 1, 2'd3, 16'h0001, 1, 0, 16'h0);
        rdc(2'd3, 16'h0003);

        // COUNT write on a tick cycle: write wins, no decrement.
        wr(2'd1, 16'd5);
        wr(2'd2, 16'd5);
        wait_tick("count_write_tick");
        wr(2'd2, 16'h00FF);
        rdc(2'd2, 16'h00FF);
        idle(3);
        rdc(2'd2, 16'h00FE);

        // Reset while running with EXP set.
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'h0001);
        wr(2'd1, 16'd2);
        wr(2'd2, 16'd0);
        wr(2'd0, 16'h0007);
        wait_exp("pre_reset_expiry");
        idle(2);
        drive(1, 0, 0, 2'd0, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) rdc(2'(i), 16'h0000);
        idle(20);
        rdc(2'd2, 16'h0000);
        rdc(2'd3, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_s   = ($urandom_range(0, 99) < 40);
            r_we  = 1'($urandom_range(0, 1));
            r_a   = 2'($urandom_range(0, 3));
            r_d   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            if (r_s && r_we && r_a == 2'd0 && $urandom_range(0, 3) != 0) r_d[0] = 1'b1;
            r_ack = ($urandom_range(0, 9) == 0);
            drive(r_rst, r_s, r_we, r_a, r_d, r_ack, 0, 16'h0);
        end
        idle(3);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_reads: got %0d left over required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
